// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state type and op-class helpers for the serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // SUB and SLT both compute A + ~B + 1
  function automatic logic b_invert(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/result bundle of the serial ALU; master issues operations, slave is the ALU.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, op,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide ALU slice: ripple adder plus bitwise logic ops.
module alu_digit
  import alu_pkg::*;
#(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             binvert,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] sum;
  logic             c;

  always_comb begin
    bx    = binvert ? ~b : b;
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout = c;
  end

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: processes WIDTH/DIGIT slices LSB first, one per cycle, with a
// registered inter-slice carry; final flags and result are published only on completion.
module serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  serial_alu_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_alu: WIDTH must be an integer multiple of DIGIT");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] s_y;
  logic             s_cout;
  logic             s_cmsb;

  alu_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a      (a_q[DIGIT-1:0]),
    .b      (b_q[DIGIT-1:0]),
    .binvert(b_invert(op_q)),
    .cin    (carry_q),
    .op     (op_q),
    .y      (s_y),
    .cout   (s_cout),
    .c_msb  (s_cmsb)
  );

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res_fin;
  logic             arith;
  logic             slice_ovf;
  logic             last;

  always_comb begin
    // New slice enters at the top; after N shifts slice 0 sits at bit 0.
    acc_next  = WIDTH'({s_y, acc_q} >> DIGIT);
    arith     = is_arith(op_q);
    slice_ovf = s_cmsb ^ s_cout;
    last      = (cnt_q == CW'(N - 1));
    res_fin   = acc_next;
    if (op_q == OP_SLT) res_fin = {{(WIDTH-1){1'b0}}, acc_next[WIDTH-1] ^ slice_ovf};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = b_invert(bus.op);
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = s_cout;
        acc_d   = acc_next;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = res_fin;
          cout_d   = arith & s_cout;
          ovf_d    = arith & slice_ovf;
          zero_d   = (res_fin == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and elaboration SHALL fail otherwise. N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled with a, b, op.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation code.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry_out  output  1  final carry of arithmetic ops.
REQ-013 overflow  output  1  signed overflow of arithmetic ops.
REQ-014 zero  output  1  result equals 0.

Function
REQ-015 op encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 NAND, 100 NOR, 101 XOR, 111 SLT (set-less-than, signed).
REQ-016 SUB and SLT: B inverted and carry-in 1; ADD: carry-in 0; logic ops: no inversion, carry ignored.
REQ-017 FSM states IDLE, RUN, DONE.
REQ-018 start SHALL be accepted only in IDLE or DONE; the accepting edge captures a, b, op into internal registers and enters RUN.
REQ-019 start while in RUN SHALL be ignored, with no effect on captured operands or progress.
REQ-020 RUN SHALL process one DIGIT-wide slice per cycle, LSB slice first, with the carry registered between slices, for exactly N cycles.
REQ-021 busy SHALL be 1 in every cycle in RUN (exactly N cycles after acceptance) and 0 otherwise.
REQ-022 After the Nth slice the FSM SHALL enter DONE; done = 1 for exactly that one cycle. The next cycle SHALL go to IDLE unless start is accepted in DONE, in which case it goes directly to RUN (back-to-back).
REQ-023 Operation latency: acceptance edge to done high SHALL be N+1 cycles.
REQ-024 result, carry_out, overflow and zero SHALL become valid in the done cycle and hold until the edge that completes the next operation. Partial results SHALL never be visible.
REQ-025 carry_out = carry out of the MSB slice for ADD/SUB/SLT, 0 for logic ops.
REQ-026 overflow = carry into MSB XOR carry out of MSB for ADD/SUB/SLT, 0 for logic ops.
REQ-027 SLT: result = {WIDTH-1 zeros, (sign of A-B) XOR overflow}; carry_out and overflow report the subtraction.
REQ-028 zero SHALL be computed on the final result, including SLT.
REQ-029 For DIGIT = WIDTH (N = 1), busy SHALL be high one cycle and done follows; all rules above SHALL hold unchanged.

Reset
REQ-030 reset = 1 at a clock edge SHALL force IDLE and clear busy, done, result, carry_out, overflow, zero, the slice counter and the carry register to 0.
REQ-031 reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-032 reset has priority over start in the same cycle.

Structure
REQ-033 Package alu_pkg SHALL hold the op-code constants and the FSM state type; serial_alu imports them.
REQ-034 One combinational sub-module, alu_digit, SHALL implement a DIGIT-wide slice (Binvert, carry-in, op in; slice result, carry-out, carry into MSB bit out). serial_alu instantiates it once.
REQ-035 Slice counter width SHALL be clog2(N), minimum 1.

Verification
REQ-036 WIDTH=8, DIGIT=1: ADD a=0x7F, b=0x01 -> done 9 cycles after acceptance; result 0x80, overflow 1, carry_out 0, zero 0.
REQ-037 WIDTH=8, DIGIT=2: SUB a=0x05, b=0x05 -> done 5 cycles after acceptance; result 0x00, zero 1, carry_out 1, overflow 0.
REQ-038 WIDTH=8: SLT a=0x80, b=0x01 -> result 0x01; then SLT a=0x01, b=0x80 -> result 0x00.
REQ-039 Logic sweep with a=0xF0, b=0x3C: AND 0x30, OR 0xFC, NAND 0xCF, NOR 0x03, XOR 0xCC; carry_out and overflow 0 for every op.
REQ-040 start pulsed mid-RUN with different operands -> ignored, original result returned; start held high through DONE -> back-to-back operation, no IDLE cycle.
REQ-041 reset asserted at slice 3 of 8 -> next cycle busy 0, all outputs 0, no done pulse; a new start then completes normally.
